fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of storage entries; must be a power of two, minimum 2.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 wr  input  1  Write request; samples wrdata on the same rising edge.
REQ-006 rd  input  1  Read request.
REQ-007 wrdata  input  DATA_W  Write data.
REQ-008 rddata  output  DATA_W  Registered read data.
REQ-009 empty  output  1  High when the FIFO holds 0 entries.
REQ-010 full  output  1  High when the FIFO holds DEPTH entries.

Function
REQ-011 Storage order is strictly first-in, first-out.
REQ-012 A write is accepted on a rising edge when wr=1 and (full=0, or rd=1 with the read accepted).
- The accepted word is stored at the write pointer.
- The write pointer then advances modulo DEPTH.
REQ-013 A read is accepted on a rising edge when rd=1 and empty=0.
- The word at the read pointer is loaded into rddata on that edge, giving 1-cycle latency.
- The read pointer then advances modulo DEPTH.
REQ-014 rddata holds its last value whenever no read is accepted.
REQ-015 A write while full with no accepted read is dropped. No state changes and no error indication are produced.
REQ-016 A read while empty is ignored. Pointers and rddata are unchanged.
REQ-017 Simultaneous wr and rd while empty: only the write takes effect, and empty deasserts on the next cycle.
REQ-018 Simultaneous wr and rd while full: both take effect, and full stays high.
REQ-019 Simultaneous wr and rd with 0 < count < DEPTH: both take effect, and the flags are unchanged.
REQ-020 Pointers are ADDR_W+1 bits wide, where ADDR_W = log2(DEPTH).
- The extra MSB acts as a wrap bit.
- empty = pointers equal.
- full = pointer addresses equal and wrap bits differ.
REQ-021 empty and full are registered or derived combinationally from registered pointers, and are glitch-free relative to clk.
REQ-022 Flags update in the same cycle as the pointer change.
REQ-023 empty and full are never high simultaneously.

Reset
REQ-024 While rst_n=0, regardless of clk:
- both pointers = 0
- rddata = 0
- empty = 1
- full = 0
REQ-025 Asserting reset mid-operation discards all stored data immediately.
REQ-026 Storage array contents are not reset.
REQ-027 After rst_n deasserts, the first rising edge is fully functional.

Configuration
REQ-028 When macro FIFO_COUNT_EN is defined, the FIFO has an extra output count (width ADDR_W+1).
- count gives the current number of stored entries, 0..DEPTH.
- count updates on the same edge as the pointers and resets to 0.
REQ-029 When FIFO_COUNT_EN is undefined, the count port and its logic are absent, and all other behaviour is identical.

Structure
REQ-030 Shared package fifo_pkg holds:
- the DATA_W and DEPTH defaults
- the ADDR_W derivation function (clog2)
REQ-031 Storage is the sub-module fifo_mem:
- DEPTH x DATA_W register array
- synchronous write port and synchronous read port
REQ-032 Pointer and flag control resides in fifo.

Verification
REQ-033 Reset check: hold rst_n=0 for 5 cycles -> empty=1, full=0, rddata=0x00.
REQ-034 Overflow check: after reset, write 0x01..0x20 on 32 consecutive cycles with rd=0.
- full rises on the edge accepting 0x10.
- 0x11..0x20 are dropped.
REQ-035 Partial drain: from REQ-034 state, hold rd=1 for 5 cycles.
- rddata = 0x01, 0x02, 0x03, 0x04, 0x05 on successive edges.
- full falls after the first read.
REQ-036 Refill: from REQ-035 state, write 0x21..0x40 on 32 cycles.
- 0x21..0x25 are accepted and full reasserts.
- A full drain then yields 0x06..0x10 followed by 0x21..0x25, after which empty=1.
REQ-037 Boundary check: with the FIFO empty, assert wr=1 and rd=1 with wrdata=0xAA.
- Only the write takes effect and empty falls.
- With the FIFO full, assert wr=1 and rd=1 with wrdata=0xBB: the oldest word is output, 0xBB is stored, and full stays 1.
REQ-038 Reset mid-stream: assert rst_n=0 asynchronously while 8 entries are held -> empty=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the fifo block.
//   DATA_W_DEF : default data word width
//   DEPTH_DEF  : default number of storage entries (power of two, >= 2)
//   addr_w()   : address width derived from a depth (clog2)
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array for the fifo.
// The write port is synchronous.
// The read port is synchronous and registered: rd_data loads on a rd_en edge
// and holds its value otherwise.
// Only the read register is reset; the array contents are left alone.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   wr_en      : store wr_data at wr_addr
//   wr_addr    : write address
//   wr_data    : write data
//   rd_en      : load mem[rd_addr] into rd_data
//   rd_addr    : read address
//   rd_data    : registered read data
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // When read and write hit the same address on one edge (full FIFO),
  // the read returns the old word because both use non-blocking updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo.sv
// fifo: single-clock first-in first-out buffer.
// Handshake:
//   wr and rd are requests, not valid/ready pairs.
//   A write is accepted on a rising edge when wr=1 and either the FIFO is not
//   full, or a read is accepted on the same edge.
//   A read is accepted on a rising edge when rd=1 and the FIFO is not empty.
//   rddata presents the read word one cycle after the request.
//   Rejected requests are silently dropped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr, wrdata : write request and data
//   rd         : read request
//   rddata     : registered read data, holds when no read is accepted
//   empty      : no entries stored
//   full       : DEPTH entries stored
//   count      : number of stored entries (only when FIFO_COUNT_EN is defined)
// Optional feature macro: FIFO_COUNT_EN
// DEPTH must be a power of two, at least 2.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [DATA_W-1:0]         wrdata,
  output logic [DATA_W-1:0]         rddata,
  output logic                      empty,
`ifdef FIFO_COUNT_EN
  output logic                      full,
  output logic [addr_w(DEPTH):0]    count
`else
  output logic                      full
`endif
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  // One extra MSB on each pointer is a wrap bit.
  // It separates full (same address, wrap differs) from empty (identical).
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            rd_ok;
  logic            wr_ok;

  // Flags are pure functions of registered pointers, so they change only
  // on clock edges and never glitch between them.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign rd_ok = rd && !empty;
  // A read on the same edge frees the slot, so a write to a full FIFO is
  // accepted when paired with an accepted read.
  assign wr_ok = wr && (!full || rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef FIFO_COUNT_EN
  // The modular difference of the wrap-extended pointers is the occupancy
  // (0..DEPTH). It follows the pointers, including their reset.
  assign count = wr_ptr - rd_ptr;
`endif

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wrdata),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rddata)
  );

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed self-checking bench for fifo (DATA_W=8, DEPTH=16).
module tb_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [7:0] wrdata;
  logic [7:0] rddata;
  logic       empty;
  logic       full;
`ifdef FIFO_COUNT_EN
  logic [4:0] count;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (wr),
    .rd     (rd),
    .wrdata (wrdata),
    .rddata (rddata),
    .empty  (empty),
`ifdef FIFO_COUNT_EN
    .full   (full),
    .count  (count)
`else
    .full   (full)
`endif
  );

  // driver: apply inputs after the falling edge, sample 1 time unit after
  // the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr     = w;
    rd     = r;
    wrdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop the expected word and compare with rddata
  task automatic rd_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=queue_empty", tag, rddata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, rddata}, {24'd0, e});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    wrdata = 8'h00;

    // reset held for 5 cycles
    repeat (5) @(posedge clk);
    #1;
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_rddata", {24'd0, rddata}, 32'h00);
`ifdef FIFO_COUNT_EN
    chk("reset_count", {27'd0, count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // overflow: 0x01..0x20, only 0x01..0x10 fit
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 1)  chk("ovf_empty_falls", {31'd0, empty}, 32'd0);
      if (i == 15) chk("ovf_not_full_15", {31'd0, full}, 32'd0);
      if (i == 16) chk("ovf_full_16", {31'd0, full}, 32'd1);
    end
    chk("ovf_full_end", {31'd0, full}, 32'd1);
    chk("ovf_rddata_hold", {24'd0, rddata}, 32'h00);
`ifdef FIFO_COUNT_EN
    chk("ovf_count", {27'd0, count}, 32'd16);
`endif

    // partial drain: 5 reads
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain5_data", {24'd0, rddata}, 32'(k));
      if (k == 1) chk("drain5_full_falls", {31'd0, full}, 32'd0);
    end

    // refill with 0x21..0x40: only 0x21..0x25 fit
    for (int i = 8'h21; i <= 8'h40; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 8'h24) chk("refill_not_full", {31'd0, full}, 32'd0);
      if (i == 8'h25) chk("refill_full", {31'd0, full}, 32'd1);
    end
    chk("refill_rddata_hold", {24'd0, rddata}, 32'h05);

    // full drain: 0x06..0x10 then 0x21..0x25
    for (int i = 6; i <= 16; i++) exp_q.push_back(8'(i));
    for (int i = 8'h21; i <= 8'h25; i++) exp_q.push_back(8'(i));
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      rd_check("full_drain_data");
    end
    chk("full_drain_empty", {31'd0, empty}, 32'd1);
    chk("full_drain_not_full", {31'd0, full}, 32'd0);

    // read while empty is ignored
    cyc(1'b0, 1'b1, 8'h00);
    chk("empty_read_hold", {24'd0, rddata}, 32'h25);
    chk("empty_read_empty", {31'd0, empty}, 32'd1);

    // wr+rd while empty: only the write takes effect
    cyc(1'b1, 1'b1, 8'hAA);
    chk("bnd_empty_falls", {31'd0, empty}, 32'd0);
    chk("bnd_empty_rddata", {24'd0, rddata}, 32'h25);
`ifdef FIFO_COUNT_EN
    chk("bnd_empty_count", {27'd0, count}, 32'd1);
`endif
    cyc(1'b0, 1'b1, 8'h00);
    chk("bnd_aa_read", {24'd0, rddata}, 32'hAA);
    chk("bnd_aa_empty", {31'd0, empty}, 32'd1);

    // wr+rd while full: oldest out, 0xBB in, full stays
    for (int i = 8'h30; i <= 8'h3F; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("bnd_full_before", {31'd0, full}, 32'd1);
    cyc(1'b1, 1'b1, 8'hBB);
    chk("bnd_full_rddata", {24'd0, rddata}, 32'h30);
    chk("bnd_full_stays", {31'd0, full}, 32'd1);
    for (int i = 8'h31; i <= 8'h3F; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hBB);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      rd_check("bnd_full_drain");
    end
    chk("bnd_full_drain_empty", {31'd0, empty}, 32'd1);

    // async reset mid-stream with 8 entries held
    for (int i = 8'h60; i <= 8'h67; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b0, 1'b0, 8'h00);
    chk("mid_not_empty", {31'd0, empty}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_full", {31'd0, full}, 32'd0);
    chk("mid_rst_rddata", {24'd0, rddata}, 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset is functional
    cyc(1'b1, 1'b0, 8'h55);
    chk("post_rst_empty", {31'd0, empty}, 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_rst_read", {24'd0, rddata}, 32'h55);
    chk("post_rst_empty2", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
